// File: rtl/tmu2_join_pkg.sv
// tmu2_join_pkg: burst geometry shared by the TMU2 split, fetch and join stages, plus the join FSM state type
package tmu2_join_pkg;
   localparam int burst_beats       = 4;
   localparam int burst_bytes       = 32;
   localparam int burst_offset_bits = 5;
   typedef enum logic [1:0] {IDLE, FILL, OUTPUT} state_t;
endpackage

// File: rtl/tmu2_join_if.sv
// tmu2_join_if: fragment, fetch-beat, cache-write and downstream fragment bundle around the join stage
interface tmu2_join_if #(
   parameter int cache_depth = 13,
   parameter int fml_depth   = 26
);
   logic                   frag_pipe_stb_i, frag_pipe_ack_o;
   logic [fml_depth-2:0]   frag_dadr;
   logic [cache_depth-1:0] frag_tadra, frag_tadrb, frag_tadrc, frag_tadrd;
   logic [5:0]             frag_x_frac, frag_y_frac;
   logic                   frag_miss_a, frag_miss_b, frag_miss_c, frag_miss_d;
   logic                   fetch_pipe_stb_i, fetch_pipe_ack_o;
   logic [63:0]            fetch_dat;
   logic                   cache_we;
   logic [cache_depth-4:0] cache_adr;
   logic [63:0]            cache_dat;
   logic                   pipe_stb_o, pipe_ack_i;
   logic [fml_depth-2:0]   dadr;
   logic [cache_depth-1:0] tadra, tadrb, tadrc, tadrd;
   logic [5:0]             x_frac, y_frac;
   modport slave (
      input  frag_pipe_stb_i, frag_dadr, frag_tadra, frag_tadrb, frag_tadrc, frag_tadrd,
             frag_x_frac, frag_y_frac, frag_miss_a, frag_miss_b, frag_miss_c, frag_miss_d,
             fetch_pipe_stb_i, fetch_dat, pipe_ack_i,
      output frag_pipe_ack_o, fetch_pipe_ack_o, cache_we, cache_adr, cache_dat,
             pipe_stb_o, dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac
   );
   modport master (
      output frag_pipe_stb_i, frag_dadr, frag_tadra, frag_tadrb, frag_tadrc, frag_tadrd,
             frag_x_frac, frag_y_frac, frag_miss_a, frag_miss_b, frag_miss_c, frag_miss_d,
             fetch_pipe_stb_i, fetch_dat, pipe_ack_i,
      input  frag_pipe_ack_o, fetch_pipe_ack_o, cache_we, cache_adr, cache_dat,
             pipe_stb_o, dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac
   );
endinterface

// File: rtl/tmu2_join.sv
// tmu2_join: writes each missed texel burst into the texel cache, then hands the fragment downstream
module tmu2_join
   import tmu2_join_pkg::*;
#(
   parameter int cache_depth = 13,
   parameter int fml_depth   = 26
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic busy,
   tmu2_join_if.slave bus
);
   state_t                 state, next_state;
   logic [3:0]             pend, pend_left;
   logic [1:0]             beat, sel;
   logic                   last_beat, accept;
   logic [cache_depth-1:0] tadr [4];
   logic [fml_depth-2:0]   dadr_q;
   logic [5:0]             x_frac_q, y_frac_q;

   // texels are serviced lowest-letter first; sel points at the one currently filling
   assign sel       = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
   assign pend_left = pend & ~(4'b0001 << sel);
   assign accept    = (state == IDLE) & bus.frag_pipe_stb_i;
   assign last_beat = bus.cache_we & (beat == 2'(burst_beats - 1));

   assign busy                 = state != IDLE;
   assign bus.frag_pipe_ack_o  = state == IDLE;
   assign bus.pipe_stb_o       = state == OUTPUT;
   // reset gates the fetch ack so a beat arriving with reset is neither acked nor written
   assign bus.fetch_pipe_ack_o = (state == FILL) & ~sys_rst;
   assign bus.cache_we         = bus.fetch_pipe_stb_i & bus.fetch_pipe_ack_o;
   assign bus.cache_adr        = {tadr[sel][cache_depth-1:burst_offset_bits], beat};
   assign bus.cache_dat        = bus.fetch_dat;

   assign bus.dadr   = dadr_q;
   assign bus.tadra  = tadr[0];
   assign bus.tadrb  = tadr[1];
   assign bus.tadrc  = tadr[2];
   assign bus.tadrd  = tadr[3];
   assign bus.x_frac = x_frac_q;
   assign bus.y_frac = y_frac_q;

   // next state: accept -> fill missed bursts (if any) -> present downstream
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = accept ? (|{bus.frag_miss_d, bus.frag_miss_c, bus.frag_miss_b, bus.frag_miss_a} ? FILL : OUTPUT) : IDLE;
         FILL:    next_state = (last_beat && pend_left == 4'd0) ? OUTPUT : FILL;
         OUTPUT:  next_state = bus.pipe_ack_i ? IDLE : OUTPUT;
         default: next_state = IDLE;
      endcase
   end

   // control state: FSM register, pending-texel flags and beat position
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= IDLE;
         pend  <= 4'd0;
         beat  <= 2'd0;
      end else begin
         state <= next_state;
         if (accept) begin
            pend <= {bus.frag_miss_d, bus.frag_miss_c, bus.frag_miss_b, bus.frag_miss_a};
            beat <= 2'd0;
         end else if (bus.cache_we) begin
            beat <= beat + 2'd1;
            if (last_beat) pend <= pend_left;
         end
      end
   end

   // fragment fields are captured on accept and held until the next accept
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         dadr_q   <= bus.frag_dadr;
         tadr[0]  <= bus.frag_tadra;
         tadr[1]  <= bus.frag_tadrb;
         tadr[2]  <= bus.frag_tadrc;
         tadr[3]  <= bus.frag_tadrd;
         x_frac_q <= bus.frag_x_frac;
         y_frac_q <= bus.frag_y_frac;
      end
   end
endmodule

// File: tb/tb_tmu2_join.sv
// tb_tmu2_join: randomized scoreboard bench for the TMU2 join stage
module tb_tmu2_join;
   import tmu2_join_pkg::*;
   localparam int cd = 13;
   localparam int fd = 26;

   typedef struct packed {
      logic [fd-2:0]         dadr;
      logic [3:0][cd-1:0]    t;
      logic [5:0]            xf;
      logic [5:0]            yf;
   } frag_t;
   typedef struct packed {
      logic [cd-4:0] adr;
      logic [63:0]   dat;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   tests = 0;
   int   fails = 0;
   wr_t   exp_wr[$];
   frag_t exp_frag[$];

   tmu2_join_if #(.cache_depth(cd), .fml_depth(fd)) bus ();

   tmu2_join #(.cache_depth(cd), .fml_depth(fd)) dut (
      .sys_clk(clk),
      .sys_rst(rst),
      .busy(busy),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event did not occur", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic frag_t rnd_frag();
      frag_t f;
      f.dadr = (fd-1)'($urandom);
      for (int i = 0; i < 4; i++) f.t[i] = cd'($urandom);
      f.xf = 6'($urandom);
      f.yf = 6'($urandom);
      return f;
   endfunction

   // monitor: every cache write and every downstream handshake is matched against the scoreboard
   always @(negedge clk) begin
      wr_t w;
      frag_t f;
      if (bus.cache_we === 1'b1) begin
         if (exp_wr.size() == 0) fail_now("unexpected_cache_write");
         else begin
            w = exp_wr.pop_front();
            check("cache_adr", 64'(bus.cache_adr), 64'(w.adr));
            check("cache_dat", bus.cache_dat, w.dat);
         end
      end
      if (bus.pipe_stb_o === 1'b1 && bus.pipe_ack_i === 1'b1) begin
         if (exp_frag.size() == 0) fail_now("unexpected_fragment");
         else begin
            f = exp_frag.pop_front();
            check("dadr", 64'(bus.dadr), 64'(f.dadr));
            check("tadra", 64'(bus.tadra), 64'(f.t[0]));
            check("tadrb", 64'(bus.tadrb), 64'(f.t[1]));
            check("tadrc", 64'(bus.tadrc), 64'(f.t[2]));
            check("tadrd", 64'(bus.tadrd), 64'(f.t[3]));
            check("x_frac", 64'(bus.x_frac), 64'(f.xf));
            check("y_frac", 64'(bus.y_frac), 64'(f.yf));
         end
      end
   end

   // one fragment: accept, deliver one 4-beat burst per miss flag in order a..d, then drain downstream
   task automatic run_frag(input frag_t f, input logic [3:0] miss, input int gap_max, input int stall, input int rst_at);
      int n;
      int k;
      bit aborted;
      wr_t w;
      logic [63:0] d;
      k = 0;
      aborted = 0;
      bus.frag_pipe_stb_i = 1'b1;
      bus.frag_dadr = f.dadr;
      bus.frag_tadra = f.t[0];
      bus.frag_tadrb = f.t[1];
      bus.frag_tadrc = f.t[2];
      bus.frag_tadrd = f.t[3];
      bus.frag_x_frac = f.xf;
      bus.frag_y_frac = f.yf;
      {bus.frag_miss_d, bus.frag_miss_c, bus.frag_miss_b, bus.frag_miss_a} = miss;
      n = 0;
      while (bus.frag_pipe_ack_o !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) fail_now("frag_accept_timeout");
      if (rst_at < 0) exp_frag.push_back(f);
      step();
      bus.frag_pipe_stb_i = 1'b0;
      bus.frag_dadr = (fd-1)'($urandom);
      bus.frag_tadra = cd'($urandom);
      bus.frag_tadrb = cd'($urandom);
      bus.frag_x_frac = 6'($urandom);
      {bus.frag_miss_d, bus.frag_miss_c, bus.frag_miss_b, bus.frag_miss_a} = 4'($urandom);
      for (int t = 0; t < 4; t++) begin
         for (int b = 0; b < 4; b++) begin
            if (miss[t] && !aborted) begin
               repeat ($urandom_range(0, gap_max)) step();
               check("fill_busy", 64'(busy), 64'(1));
               check("fill_no_stb", 64'(bus.pipe_stb_o), 64'(0));
               d = {$urandom, $urandom};
               bus.fetch_pipe_stb_i = 1'b1;
               bus.fetch_dat = d;
               if (k == rst_at) begin
                  rst = 1'b1;
                  step();
                  rst = 1'b0;
                  bus.fetch_pipe_stb_i = 1'b0;
                  check("rst_busy", 64'(busy), 64'(0));
                  check("rst_pipe_stb", 64'(bus.pipe_stb_o), 64'(0));
                  check("rst_frag_ack", 64'(bus.frag_pipe_ack_o), 64'(1));
                  check("rst_fetch_ack", 64'(bus.fetch_pipe_ack_o), 64'(0));
                  aborted = 1;
               end else begin
                  w.adr = (cd-3)'(int'(f.t[t]) / 32 * 4 + b);
                  w.dat = d;
                  exp_wr.push_back(w);
                  n = 0;
                  while (bus.fetch_pipe_ack_o !== 1'b1 && n < 20) begin step(); n++; end
                  if (n >= 20) fail_now("fetch_ack_timeout");
                  step();
                  bus.fetch_pipe_stb_i = 1'b0;
               end
               k++;
            end
         end
      end
      if (aborted) return;
      check("out_latency", 64'(bus.pipe_stb_o), 64'(1));
      repeat (stall) begin
         bus.fetch_pipe_stb_i = 1'($urandom);
         #1;
         check("stall_stb", 64'(bus.pipe_stb_o), 64'(1));
         check("stall_frag_ack", 64'(bus.frag_pipe_ack_o), 64'(0));
         check("stall_fetch_ack", 64'(bus.fetch_pipe_ack_o), 64'(0));
         check("stall_dadr", 64'(bus.dadr), 64'(f.dadr));
         check("stall_tadrd", 64'(bus.tadrd), 64'(f.t[3]));
         step();
      end
      bus.fetch_pipe_stb_i = 1'b0;
      bus.pipe_ack_i = 1'b1;
      n = 0;
      while (bus.pipe_stb_o !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) fail_now("pipe_stb_timeout");
      step();
      bus.pipe_ack_i = 1'b0;
      check("idle_after_ack", 64'(bus.frag_pipe_ack_o), 64'(1));
      check("no_stb_after_ack", 64'(bus.pipe_stb_o), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      frag_t f;
      bus.frag_pipe_stb_i = 1'b0;
      bus.frag_dadr = '0;
      bus.frag_tadra = '0;
      bus.frag_tadrb = '0;
      bus.frag_tadrc = '0;
      bus.frag_tadrd = '0;
      bus.frag_x_frac = '0;
      bus.frag_y_frac = '0;
      {bus.frag_miss_d, bus.frag_miss_c, bus.frag_miss_b, bus.frag_miss_a} = 4'd0;
      bus.fetch_pipe_stb_i = 1'b0;
      bus.fetch_dat = '0;
      bus.pipe_ack_i = 1'b0;
      repeat (3) step();
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_pipe_stb", 64'(bus.pipe_stb_o), 64'(0));
      check("reset_frag_ack", 64'(bus.frag_pipe_ack_o), 64'(1));
      check("reset_fetch_ack", 64'(bus.fetch_pipe_ack_o), 64'(0));
      check("reset_cache_we", 64'(bus.cache_we), 64'(0));
      rst = 1'b0;
      step();
      f = rnd_frag();
      f.dadr = 25'h1234;
      run_frag(f, 4'b0000, 0, 0, -1);
      f = rnd_frag();
      f.t[1] = 13'h0A40;
      run_frag(f, 4'b0010, 0, 0, -1);
      run_frag(rnd_frag(), 4'b1111, 3, 0, -1);
      run_frag(rnd_frag(), 4'b0101, 1, 10, -1);
      bus.fetch_pipe_stb_i = 1'b1;
      bus.fetch_dat = {$urandom, $urandom};
      repeat (3) begin
         #1;
         check("stray_fetch_ack", 64'(bus.fetch_pipe_ack_o), 64'(0));
         step();
      end
      bus.fetch_pipe_stb_i = 1'b0;
      run_frag(rnd_frag(), 4'b1111, 1, 0, 10);
      run_frag(rnd_frag(), 4'b0000, 0, 2, -1);
      for (int i = 0; i < 25; i++)
         run_frag(rnd_frag(), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1);
      repeat (3) step();
      check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
      check("frag_queue_empty", 64'(exp_frag.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/tmu2_join.md
# tmu2_join

Rejoins the two streams that the TMU2 split stage forks: fragments from the fragment FIFO and texel bursts returned by the texel fetch unit. For each fragment, the block writes every missed texel's 4×64-bit burst into the texel cache at the fragment's cache address. It then presents the fragment downstream to the texel read/filter stage, which may then read all four texels from cache. It sits between the fragment FIFO / fetch unit and the cache read stage.

## Interface
- cache_depth, 13: log2 of texel cache size in bytes.
- fml_depth, 26: FML address width in bytes.

- sys_clk  in  1  system clock; sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- busy  out  1  high whenever state is not IDLE.
- frag_pipe_stb_i  in  1  fragment valid.
- frag_pipe_ack_o  out  1  fragment accepted.
- frag_dadr  in  fml_depth-1  destination address (16-bit pixel units).
- frag_tadra..frag_tadrd  in  cache_depth each  texel cache byte addresses.
- frag_x_frac, frag_y_frac  in  6 each  bilinear fractions.
- frag_miss_a..frag_miss_d  in  1 each  texel missed; its burst follows on fetch port.
- fetch_pipe_stb_i  in  1  fetch beat valid.
- fetch_pipe_ack_o  out  1  fetch beat accepted.
- fetch_dat  in  64  burst data word.
- cache_we  out  1  cache write strobe.
- cache_adr  out  cache_depth-3  cache 64-bit word address.
- cache_dat  out  64  cache write data.
- pipe_stb_o  out  1  joined fragment valid.
- pipe_ack_i  in  1  downstream accepts.
- dadr  out  fml_depth-1; tadra..tadrd  out  cache_depth each; x_frac, y_frac  out  6 each: registered fragment fields.

## Operation
- States: IDLE, FILL, OUTPUT.
- IDLE: frag_pipe_ack_o=1. On frag_pipe_stb_i, all fragment fields and miss flags are registered. Next state is FILL if any miss, else OUTPUT.
- FILL: services missed texels in fixed order a, b, c, d, skipping clear flags. For each, accept exactly 4 beats; beat counter 2 bits, 0..3.
- fetch_pipe_ack_o = (state==FILL); it is combinational.
- cache_we = fetch_pipe_stb_i & fetch_pipe_ack_o.
- cache_adr = {tadrX[cache_depth-1:5], beat[1:0]}; cache_dat = fetch_dat.
- After beat 3 of a texel, clear its pending flag and advance to the next pending texel. After beat 3 of the last pending texel, go to OUTPUT.
- Identical addresses on several missed texels are still filled once per asserted flag; the fetch unit delivers one burst per flag.
- OUTPUT: pipe_stb_o=1. On pipe_ack_i go to IDLE. Output fields hold stable while pipe_stb_o is high.
- Fetch beats presented outside FILL are not acknowledged and are not written.

## Timing
- Reset values: state IDLE, pipe_stb_o 0, busy 0, cache_we 0, fetch_pipe_ack_o 0, frag_pipe_ack_o 1 (state IDLE), pending flags 0, beat counter 0.
- Data fields are not reset.
- No-miss latency: fragment accepted at cycle N, pipe_stb_o high at N+1.
- k misses with back-to-back beats: FILL spans cycles N+1..N+4k, and pipe_stb_o is high at N+4k+1.
- Gaps in fetch_pipe_stb_i stall FILL without losing beat position.
- Throughput: after pipe_ack_i, IDLE for at least one cycle, so there are at least 2 cycles per fragment.
- The cache write commits in the same cycle as the beat handshake. Data is therefore in cache before pipe_stb_o rises.
- Reset asserted mid-FILL or mid-OUTPUT returns to IDLE next cycle. The partial burst and the held fragment are discarded, and no further cache writes occur.

## Structure
- Single module. State encodings are localparams.
- Burst length (4 beats, 32 bytes, 5 offset bits) goes in the shared TMU2 header so the split, fetch and join stages agree.
- No sub-module.

## Test plan
- No miss: fragment with dadr=0x1234 and misses 0000 -> pipe_stb_o one cycle after accept, fields echoed, cache_we never asserted.
- Single miss b, tadrb=0x0A40, beats D0..D3 back-to-back -> writes to word addresses 0x148..0x14B with D0..D3. pipe_stb_o rises the cycle after D3.
- All four miss, beats with random stb gaps -> 16 writes in order a, b, c, d, each with correct line address and beat index; no beats lost or repeated.
- Downstream stall: pipe_ack_i low for 10 cycles -> pipe_stb_o and fields stable, frag_pipe_ack_o=0, fetch_pipe_ack_o=0.
- Stray fetch beat while in IDLE -> not acked, no cache write.
- sys_rst during beat 2 of texel c -> next cycle IDLE, busy=0, pipe_stb_o=0. A following no-miss fragment completes normally.
